// File: rtl/seletor_opcao_if.sv
// seletor_opcao_if: button, lock and selection signals between the game controller and the menu selector
interface seletor_opcao_if;
  logic habilita;
  logic botao_prox;
  logic botao_ant;
  logic botao_ok;
  logic libera;
  logic [3:0] sel;
  logic escolhido;
  logic travado;
  logic [1:0] db_estado;
  modport master (
    output habilita, botao_prox, botao_ant, botao_ok, libera,
    input sel, escolhido, travado, db_estado
  );
  modport slave (
    input habilita, botao_prox, botao_ant, botao_ok, libera,
    output sel, escolhido, travado, db_estado
  );
endinterface

// File: rtl/seletor_opcao.sv
// seletor_opcao: wrap-around menu index for the 13-way byte mux, with confirm pulse and lock.
// Define SELETOR_AUTOREPEAT_EN to step sel automatically while a direction button is held.
module seletor_opcao #(
  parameter int N_OPCOES = 13,
  parameter int HOLD_CYCLES = 50000000,
  parameter int REPEAT_CYCLES = 10000000
) (
  input logic clock,
  input logic reset,
  seletor_opcao_if.slave bus
);
  typedef enum logic [1:0] {
    OCIOSO = 2'd0,
    NAVEGA = 2'd1,
    CONFIRMA = 2'd2,
    TRAVADO = 2'd3
  } estado_t;
  localparam logic [3:0] ULTIMO = 4'(N_OPCOES - 1);
  if (N_OPCOES < 2 || N_OPCOES > 16 || HOLD_CYCLES < 1 || REPEAT_CYCLES < 1) begin : g_cfg_invalida
    $error("seletor_opcao: parameter out of range");
  end
  estado_t estado;
  logic [3:0] sel_r;
  logic escolhido_r;
  logic travado_r;
  logic prox_q;
  logic ant_q;
  logic ok_q;
  logic prox_e;
  logic ant_e;
  logic ok_e;
  logic [3:0] sel_mais;
  logic [3:0] sel_menos;
  logic passo_auto;
  assign prox_e = bus.botao_prox & ~prox_q;
  assign ant_e = bus.botao_ant & ~ant_q;
  assign ok_e = bus.botao_ok & ~ok_q;
  assign sel_mais = sel_r == ULTIMO ? 4'd0 : sel_r + 4'd1;
  assign sel_menos = sel_r == 4'd0 ? ULTIMO : sel_r - 4'd1;
`ifdef SELETOR_AUTOREPEAT_EN
  logic [31:0] cnt;
  logic repete;
  logic segura;
  // Exactly one direction held while browsing; any new edge restarts the hold timer
  assign segura = estado == NAVEGA && bus.habilita && !ok_e && (bus.botao_prox ^ bus.botao_ant);
  assign passo_auto = segura && !prox_e && !ant_e &&
                      cnt == (repete ? 32'(REPEAT_CYCLES - 1) : 32'(HOLD_CYCLES - 1));
  always_ff @(posedge clock) begin
    if (reset || !segura || prox_e || ant_e) begin
      cnt <= '0;
      repete <= 1'b0;
    end else if (passo_auto) begin
      cnt <= '0;
      repete <= 1'b1;
    end else begin
      cnt <= cnt + 32'd1;
    end
  end
`else
  assign passo_auto = 1'b0;
`endif
  always_ff @(posedge clock) begin
    if (reset) begin
      estado <= OCIOSO;
      sel_r <= 4'd0;
      escolhido_r <= 1'b0;
      travado_r <= 1'b0;
      prox_q <= 1'b1;
      ant_q <= 1'b1;
      ok_q <= 1'b1;
    end else begin
      prox_q <= bus.botao_prox;
      ant_q <= bus.botao_ant;
      ok_q <= bus.botao_ok;
      escolhido_r <= 1'b0;
      case (estado)
        OCIOSO: if (bus.habilita) estado <= NAVEGA;
        NAVEGA: begin
          if (!bus.habilita) estado <= OCIOSO;
          else if (ok_e) begin
            estado <= CONFIRMA;
            escolhido_r <= 1'b1;
          end else if (prox_e ^ ant_e) sel_r <= prox_e ? sel_mais : sel_menos;
          else if (passo_auto) sel_r <= bus.botao_prox ? sel_mais : sel_menos;
        end
        CONFIRMA: begin
          estado <= TRAVADO;
          travado_r <= 1'b1;
        end
        TRAVADO: if (bus.libera) begin
          estado <= bus.habilita ? NAVEGA : OCIOSO;
          travado_r <= 1'b0;
        end
      endcase
    end
  end
  assign bus.sel = sel_r;
  assign bus.escolhido = escolhido_r;
  assign bus.travado = travado_r;
  assign bus.db_estado = estado;
endmodule

// File: tb/tb_seletor_opcao.sv
// tb_seletor_opcao: vector table plus reset/lock/auto-repeat sequences for seletor_opcao
module tb_seletor_opcao;
  typedef struct packed {
    logic hab, prox, ant, ok, lib;
    logic [3:0] sel;
    logic esc, trav;
    logic [1:0] est;
  } vec_t;
  typedef struct packed {
    logic [3:0] sel;
    logic esc, trav;
    logic [1:0] est;
  } exp_t;
`ifdef SELETOR_AUTOREPEAT_EN
  localparam int AR_SEL = 6;
`else
  localparam int AR_SEL = 1;
`endif
  logic clock = 1'b0;
  logic reset = 1'b1;
  int tests = 0;
  int failed = 0;
  vec_t tab[$];
  exp_t sb[$];
  seletor_opcao_if vif ();
  seletor_opcao #(.N_OPCOES(13), .HOLD_CYCLES(10), .REPEAT_CYCLES(4)) dut (
    .clock(clock),
    .reset(reset),
    .bus(vif)
  );
  always #5 clock = ~clock;
  function automatic void add(input logic hab, prox, ant, ok, lib, input int sel,
                              input logic esc, trav, input int est);
    tab.push_back({hab, prox, ant, ok, lib, 4'(sel), esc, trav, 2'(est)});
  endfunction
  task automatic check(input string nome, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      failed++;
      $display("FAIL %s: got %0d expected %0d", nome, got, exp);
    end
  endtask
  task automatic aplica(input vec_t v, input string nome);
    exp_t r;
    vif.habilita = v.hab;
    vif.botao_prox = v.prox;
    vif.botao_ant = v.ant;
    vif.botao_ok = v.ok;
    vif.libera = v.lib;
    sb.push_back({v.sel, v.esc, v.trav, v.est});
    @(posedge clock);
    #1;
    r = sb.pop_front();
    check({nome, " sel"}, 32'(vif.sel), 32'(r.sel));
    check({nome, " escolhido"}, 32'(vif.escolhido), 32'(r.esc));
    check({nome, " travado"}, 32'(vif.travado), 32'(r.trav));
    check({nome, " db_estado"}, 32'(vif.db_estado), 32'(r.est));
  endtask
  initial begin
    add(1, 0, 0, 0, 0, 0, 0, 0, 1);
    for (int i = 1; i <= 13; i++) begin
      add(1, 1, 0, 0, 0, i % 13, 0, 0, 1);
      add(1, 0, 0, 0, 0, i % 13, 0, 0, 1);
    end
    add(1, 0, 1, 0, 0, 12, 0, 0, 1);
    add(1, 0, 0, 0, 0, 12, 0, 0, 1);
    add(1, 1, 1, 0, 0, 12, 0, 0, 1);
    add(1, 0, 0, 0, 0, 12, 0, 0, 1);
    for (int i = 0; i <= 5; i++) begin
      add(1, 1, 0, 0, 0, i, 0, 0, 1);
      add(1, 0, 0, 0, 0, i, 0, 0, 1);
    end
    add(1, 1, 0, 1, 0, 5, 1, 0, 2);
    add(1, 0, 0, 0, 0, 5, 0, 1, 3);
    add(1, 1, 0, 0, 0, 5, 0, 1, 3);
    add(1, 0, 0, 0, 0, 5, 0, 1, 3);
    add(1, 0, 1, 0, 0, 5, 0, 1, 3);
    add(1, 0, 0, 0, 0, 5, 0, 1, 3);
    add(1, 0, 0, 1, 0, 5, 0, 1, 3);
    add(1, 0, 0, 0, 0, 5, 0, 1, 3);
    add(1, 0, 0, 0, 1, 5, 0, 0, 1);
    add(1, 0, 0, 0, 0, 5, 0, 0, 1);
    add(1, 1, 0, 0, 0, 6, 0, 0, 1);
    add(1, 0, 0, 0, 0, 6, 0, 0, 1);
    add(1, 0, 0, 1, 0, 6, 1, 0, 2);
    add(1, 0, 0, 0, 0, 6, 0, 1, 3);
    add(0, 0, 0, 0, 1, 6, 0, 0, 0);
    add(0, 1, 0, 0, 0, 6, 0, 0, 0);
    add(0, 0, 0, 0, 0, 6, 0, 0, 0);
    add(1, 0, 0, 0, 0, 6, 0, 0, 1);
    add(0, 0, 0, 1, 0, 6, 0, 0, 0);
    add(0, 0, 0, 0, 0, 6, 0, 0, 0);
    reset = 1'b1;
    aplica({5'b0, 4'd0, 1'b0, 1'b0, 2'd0}, "reset");
    reset = 1'b0;
    foreach (tab[i]) aplica(tab[i], $sformatf("v%0d", i));
    reset = 1'b1;
    aplica({5'b01000, 4'd0, 1'b0, 1'b0, 2'd0}, "prox_held_reset");
    reset = 1'b0;
    for (int i = 0; i < 3; i++) aplica({5'b11000, 4'd0, 1'b0, 1'b0, 2'd1}, $sformatf("prox_held%0d", i));
    aplica({5'b10000, 4'd0, 1'b0, 1'b0, 2'd1}, "prox_held_release");
    for (int i = 1; i <= 7; i++) begin
      aplica({5'b11000, 4'(i), 1'b0, 1'b0, 2'd1}, $sformatf("to7_p%0d", i));
      aplica({5'b10000, 4'(i), 1'b0, 1'b0, 2'd1}, $sformatf("to7_r%0d", i));
    end
    aplica({5'b10010, 4'd7, 1'b1, 1'b0, 2'd2}, "ok7");
    aplica({5'b10000, 4'd7, 1'b0, 1'b1, 2'd3}, "lock7");
    reset = 1'b1;
    aplica({5'b10000, 4'd0, 1'b0, 1'b0, 2'd0}, "reset_in_lock");
    reset = 1'b0;
    aplica({5'b10000, 4'd0, 1'b0, 1'b0, 2'd1}, "renav");
    vif.botao_prox = 1'b1;
    repeat (30) @(posedge clock);
    #1;
    vif.botao_prox = 1'b0;
    @(posedge clock);
    #1;
    check("autorepeat sel", 32'(vif.sel), 32'(AR_SEL));
    check("autorepeat db_estado", 32'(vif.db_estado), 32'd1);
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule

// File: doc/seletor_opcao.md
# seletor_opcao

Menu-selection controller that produces the 4-bit index driving the select input of the 13-way byte multiplexer in the game datapath. Three buttons move the index forward and back with wrap-around and confirm a choice. Confirmation emits a one-cycle pulse and locks the index until the game controller releases it. The block never emits an index outside 0..N_OPCOES-1, so the multiplexer's default branch is never selected.

## Interface
- N_OPCOES, 13, number of selectable options; legal range 2..16
- HOLD_CYCLES, 50000000, cycles a direction button must stay held before the first auto-repeat step (macro builds only)
- REPEAT_CYCLES, 10000000, cycles between subsequent auto-repeat steps (macro builds only)

- clock  in  1  system clock; all logic on its rising edge
- reset  in  1  synchronous, active-high
- habilita  in  1  enables browsing; level
- botao_prox  in  1  next-option button; already synchronized and debounced; level
- botao_ant  in  1  previous-option button; same conditioning as botao_prox
- botao_ok  in  1  confirm button; same conditioning as botao_prox
- libera  in  1  releases the lock; level
- sel  out  4  current option index; drives the multiplexer SEL input
- escolhido  out  1  one-cycle pulse when a choice is confirmed
- travado  out  1  high while the choice is locked
- db_estado  out  2  state encoding, for debug

## Operation
- States and encodings:
  - OCIOSO = 0
  - NAVEGA = 1
  - CONFIRMA = 2
  - TRAVADO = 3
- Edge detection:
  - Each button has a registered previous sample.
  - An "edge" is current = 1 while previous = 0.
  - Reset loads all previous samples with 1. A button held through reset therefore produces no edge.
- OCIOSO:
  - sel holds its value.
  - habilita = 1 -> NAVEGA.
- NAVEGA:
  - habilita = 0 -> OCIOSO. This has priority over all button activity.
  - ok edge -> CONFIRMA. sel keeps its current value, even if prox/ant edges occur in the same cycle.
  - prox edge only: sel = sel + 1, wrapping from N_OPCOES-1 to 0.
  - ant edge only: sel = sel - 1, wrapping from 0 to N_OPCOES-1.
  - prox and ant edges in the same cycle: no change.
- CONFIRMA: lasts exactly one cycle, with escolhido = 1; always -> TRAVADO. habilita is ignored here.
- TRAVADO:
  - travado = 1; sel is frozen; buttons are ignored, but previous samples keep updating.
  - libera = 1 -> NAVEGA if habilita = 1, otherwise -> OCIOSO.
- Arithmetic: the wrap comparison uses N_OPCOES-1 as a 4-bit constant. sel is always in 0..N_OPCOES-1.
- Reset values:
  - sel = 0
  - escolhido = 0
  - travado = 0
  - db_estado = 0 (OCIOSO)
  - auto-repeat counter = 0
- Reset asserted mid-operation, including in CONFIRMA or TRAVADO, overrides everything on the next edge.

## Timing
- All outputs are registered.
- Input change sampled at clock edge k:
  - sel updates after edge k.
  - escolhido is high for the cycle following the transition into CONFIRMA.
  - travado rises one cycle after escolhido.
- Latency from the ok edge to escolhido: 1 cycle.
- escolhido is never high for two consecutive cycles.
- libera sampled at edge k: travado = 0 after edge k.
- Back-to-back prox edges require at least one sample at 0 between them. Maximum step rate is one step per two cycles.

## Configuration
- SELETOR_AUTOREPEAT_EN defined:
  - In NAVEGA, a 32-bit counter tracks the currently held direction button (prox or ant alone).
  - The counter starts at 0 on the button's edge.
  - After HOLD_CYCLES further cycles held, sel takes one more step in that direction and the counter reloads to 0.
  - Subsequent steps occur every REPEAT_CYCLES while the button is still held.
  - Releasing the button, pressing both directions, an ok edge, or leaving NAVEGA clears the counter.
- SELETOR_AUTOREPEAT_EN undefined: no counter is built; only edges move sel. HOLD_CYCLES and REPEAT_CYCLES are unused.

## Test plan
- Reset, habilita = 1, 13 single prox pulses -> sel goes 1..12 then 0; db_estado = 1 throughout.
- From sel = 0, one ant pulse -> sel = 12. Simultaneous prox + ant pulse -> sel unchanged.
- sel = 5, ok pulse together with a prox pulse:
  - escolhido = 1 for exactly one cycle with sel = 5.
  - travado = 1 afterwards.
  - Further prox/ant/ok pulses leave sel = 5 and escolhido = 0.
- In TRAVADO:
  - libera with habilita = 1 -> NAVEGA and travado = 0.
  - libera with habilita = 0 -> OCIOSO.
  - Prox presses in OCIOSO leave sel unchanged.
- botao_prox held high across reset release -> no step. Reset pulse while in TRAVADO with sel = 7 -> sel = 0, travado = 0, db_estado = 0 next cycle.
- With SELETOR_AUTOREPEAT_EN, HOLD_CYCLES = 10 and REPEAT_CYCLES = 4, hold prox for 30 cycles from sel = 0 -> steps at edge, +10, +14, +18, +22, +26, ending with sel = 6. Without the macro, the same stimulus ends with sel = 1.
